// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer. Each entry holds a valid bit, a tag,
//   a target and a saturating direction counter. Fetch looks the table up
//   combinationally; decode trains a hit entry or allocates a new one on a
//   taken miss. Two saturating statistics counters track allocations and
//   update hits.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   flush                invalidate all entries at the next edge
//   pc4_f                fetch-side PC+4 to look up
//   hit_f/taken_f/target_f  lookup result (combinational)
//   upd_valid/upd_pc4/upd_taken/upd_target  resolved-branch update
//   alloc_count          saturating count of allocations
//   upd_hit_count        saturating count of updates that hit
module branch_target_predictor #(
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [31:0]       pc4_f,
  output logic              hit_f,
  output logic              taken_f,
  output logic [31:0]       target_f,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc4,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  output logic [STAT_W-1:0] alloc_count,
  output logic [STAT_W-1:0] upd_hit_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Weakly taken is the lower edge of the upper half; weakly not-taken sits
  // just below it (0 for a single-bit counter).
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];
  logic [STAT_W-1:0]  r_alloc_count;
  logic [STAT_W-1:0]  r_upd_hit_count;

  logic [IDX_W-1:0] w_idx_f;
  logic [TAG_W-1:0] w_tag_f;
  logic [IDX_W-1:0] w_idx_u;
  logic [TAG_W-1:0] w_tag_u;
  logic             w_hit_f;
  logic             w_hit_u;
  logic             w_unused_pc_bits;

  assign w_idx_f = pc4_f[IDX_W+1:2];
  assign w_tag_f = pc4_f[31:IDX_W+2];
  assign w_idx_u = upd_pc4[IDX_W+1:2];
  assign w_tag_u = upd_pc4[31:IDX_W+2];
  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused_pc_bits = ^{pc4_f[1:0], upd_pc4[1:0]};

  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign w_hit_u = r_valid[w_idx_u] && (r_tag[w_idx_u] == w_tag_u);

  assign hit_f         = w_hit_f;
  assign taken_f       = w_hit_f && r_cnt[w_idx_f][CNT_W-1];
  assign target_f      = w_hit_f ? r_target[w_idx_f] : 32'h0;
  assign alloc_count   = r_alloc_count;
  assign upd_hit_count = r_upd_hit_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_alloc_count   <= '0;
      r_upd_hit_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (flush) begin
      // Flush wins over a same-cycle update, stats included.
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_hit_u) begin
        if (upd_taken) begin
          if (r_cnt[w_idx_u] != CNT_MAX) r_cnt[w_idx_u] <= r_cnt[w_idx_u] + CNT_W'(1);
          r_target[w_idx_u] <= upd_target;
        end else if (r_cnt[w_idx_u] != '0) begin
          r_cnt[w_idx_u] <= r_cnt[w_idx_u] - CNT_W'(1);
        end
        if (r_upd_hit_count != '1) r_upd_hit_count <= r_upd_hit_count + STAT_W'(1);
      end else if (upd_taken) begin
        // Allocation simply overwrites whatever aliased into this slot.
        r_valid[w_idx_u]  <= 1'b1;
        r_tag[w_idx_u]    <= w_tag_u;
        r_target[w_idx_u] <= upd_target;
        r_cnt[w_idx_u]    <= CNT_WT;
        if (r_alloc_count != '1) r_alloc_count <= r_alloc_count + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  localparam int IDX  = 4;
  localparam int CW   = 2;
  localparam int SW   = 6;           // narrow stats so saturation is reached
  localparam int ENT  = 1 << IDX;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [31:0]   pc4_f;
  logic          hit_f;
  logic          taken_f;
  logic [31:0]   target_f;
  logic          upd_valid;
  logic [31:0]   upd_pc4;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic [SW-1:0] alloc_count;
  logic [SW-1:0] upd_hit_count;

  int tests = 0;
  int fails = 0;

  // Reference model: plain per-slot records, counter as an integer level.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  int          m_alloc;
  int          m_hits;

  always #5 clk = ~clk;

  branch_target_predictor #(.IDX_W(IDX), .CNT_W(CW), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pc4_f(pc4_f),
    .hit_f(hit_f), .taken_f(taken_f), .target_f(target_f),
    .upd_valid(upd_valid), .upd_pc4(upd_pc4), .upd_taken(upd_taken),
    .upd_target(upd_target), .alloc_count(alloc_count),
    .upd_hit_count(upd_hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ENT; k++) begin
      m_valid[k] = 0;
      m_tag[k]   = 0;
      m_tgt[k]   = 0;
      m_cnt[k]   = (CMAX + 1) / 2 - 1;
    end
    m_alloc = 0;
    m_hits  = 0;
  endtask

  task automatic model_update(input bit fl, input bit uv, input logic [31:0] pc,
                              input bit t, input logic [31:0] tg);
    int i;
    logic [31:0] tv;
    i  = int'((pc / 4) % ENT);
    tv = pc >> (IDX + 2);
    if (fl) begin
      for (int k = 0; k < ENT; k++) m_valid[k] = 0;
    end else if (uv) begin
      if (m_valid[i] && m_tag[i] == tv) begin
        if (t) begin
          m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
          m_tgt[i] = tg;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
        m_hits = (m_hits + 1 > SMAX) ? SMAX : m_hits + 1;
      end else if (t) begin
        m_valid[i] = 1;
        m_tag[i]   = tv;
        m_tgt[i]   = tg;
        m_cnt[i]   = (CMAX + 1) / 2;
        m_alloc    = (m_alloc + 1 > SMAX) ? SMAX : m_alloc + 1;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    int i;
    bit  eh;
    i  = int'((pc4_f / 4) % ENT);
    eh = m_valid[i] && (m_tag[i] == (pc4_f >> (IDX + 2)));
    chk({ctx, " hit_f"},    {31'b0, hit_f},   {31'b0, eh});
    chk({ctx, " taken_f"},  {31'b0, taken_f}, {31'b0, eh && (m_cnt[i] > CMAX / 2)});
    chk({ctx, " target_f"}, target_f,         eh ? m_tgt[i] : 32'h0);
    chk({ctx, " alloc"},    32'(alloc_count),   32'(m_alloc));
    chk({ctx, " upd_hit"},  32'(upd_hit_count), 32'(m_hits));
  endtask

  // Called just after a falling edge: drive, check pre-edge lookup, clock.
  task automatic cycle(input string ctx, input bit fl, input bit uv, input logic [31:0] upc,
                       input bit t, input logic [31:0] tg, input logic [31:0] lpc);
    flush = fl; upd_valid = uv; upd_pc4 = upc; upd_taken = t; upd_target = tg; pc4_f = lpc;
    #1;
    check_all(ctx);
    @(posedge clk);
    if (rst_n) model_update(fl, uv, upc, t, tg);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, ENT - 1)) << 2)
        | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) p[31] = 1'b1;
    return p;
  endfunction

  initial begin
    logic [31:0] up, lp;
    rst_n = 1'b0; flush = 0; upd_valid = 0; upd_pc4 = 0; upd_taken = 0; upd_target = 0;
    pc4_f = 32'h44;
    model_reset();
    #1;
    check_all("reset");
    chk("reset hit const", {31'b0, hit_f}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Allocate 0x44 taken -> weakly taken, target 0x100.
    cycle("alloc44", 0, 1, 32'h44, 1, 32'h100, 32'h44);
    cycle("look44", 0, 0, 0, 0, 0, 32'h44);
    chk("alloc target const", target_f, 32'h100);
    // Three not-taken then two taken.
    cycle("nt1", 0, 1, 32'h44, 0, 32'h0, 32'h44);
    cycle("nt2", 0, 1, 32'h44, 0, 32'h0, 32'h44);
    cycle("nt3", 0, 1, 32'h44, 0, 32'h0, 32'h44);
    cycle("t1", 0, 1, 32'h44, 1, 32'h104, 32'h44);
    cycle("t2", 0, 1, 32'h44, 1, 32'h108, 32'h44);
    cycle("after_t", 0, 0, 0, 0, 0, 32'h44);
    chk("hit count const", 32'(upd_hit_count), 32'd5);
    // Aliasing allocation 0x84 evicts 0x44.
    cycle("alias84", 0, 1, 32'h84, 1, 32'h200, 32'h84);
    cycle("look44b", 0, 0, 0, 0, 0, 32'h44);
    cycle("look84", 0, 0, 0, 0, 0, 32'h84);
    // Flush beats a same-cycle update.
    cycle("flush", 1, 1, 32'h44, 1, 32'h300, 32'h84);
    cycle("post_flush84", 0, 0, 0, 0, 0, 32'h84);
    cycle("post_flush44", 0, 0, 0, 0, 0, 32'h44);
    // Reallocate; same-cycle lookup sees pre-update state.
    cycle("realloc_same", 0, 1, 32'h44, 1, 32'h400, 32'h44);
    cycle("realloc_next", 0, 1, 32'h44, 0, 32'h0, 32'h44);
    cycle("realloc_nt", 0, 0, 0, 0, 0, 32'h44);

    // Async reset in the middle of an update, no clock edge needed.
    flush = 0; upd_valid = 1; upd_pc4 = 32'h84; upd_taken = 1; upd_target = 32'h500;
    cycle("pre_rst", 0, 1, 32'h44, 1, 32'h600, 32'h44);
    pc4_f = 32'h44; upd_valid = 1; upd_pc4 = 32'h84; upd_taken = 1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    pc4_f = 32'h84;
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    cycle("first_after_rst", 0, 1, 32'h84, 1, 32'h700, 32'h84);
    cycle("first_after_rst2", 0, 0, 0, 0, 0, 32'h84);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      up = rand_pc();
      lp = ($urandom_range(0, 3) == 0) ? up : rand_pc();
      cycle("rand", $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, up,
            $urandom_range(0, 1) == 1, $urandom, lp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating-counter direction prediction.
- Direct-mapped: ENTRIES = 2**IDX_W. Each entry holds a valid bit, tag, target and CNT_W-bit counter.
- Fetch side: combinational lookup indexed by PC+4.
- Decode/resolve side: one update per cycle that trains the counter or allocates a new entry.
- Adds to the single-bit table: valid bits, flush, counter hysteresis, allocate-on-taken policy and saturating statistics counters.

Parameters:
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W, legal range 1..10.
- CNT_W, 2, prediction counter width, legal range 1..4.
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous invalidate of all entries.
- pc4_f  input  32  fetch PC+4 to look up.
- hit_f  output  1  entry valid and tag matches.
- taken_f  output  1  predicted taken.
- target_f  output  32  predicted destination PC.
- upd_valid  input  1  update strobe from decode.
- upd_pc4  input  32  PC+4 of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_target  input  32  actual branch destination.
- alloc_count  output  STAT_W  number of allocations performed.
- upd_hit_count  output  STAT_W  number of updates that hit an existing entry.

Behaviour:
- Field split, TAG_W = 30-IDX_W:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] ignored.
- Reset (async, while rst_n=0), takes effect immediately with no clock needed:
  - all valid=0
  - all counters = 2**(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1)
  - tags and targets = 0
  - alloc_count = 0, upd_hit_count = 0
  - so hit_f=0, taken_f=0, target_f=0.
- Lookup (zero latency, combinational from pc4_f and stored state):
  - hit_f = valid[idx] & (tag[idx]==tag(pc4_f)).
  - taken_f = hit_f & counter[idx][CNT_W-1].
  - target_f = hit_f ? target[idx] : 0.
- Update (registered, effective on the clock edge when upd_valid=1 and flush=0):
  - Upd-hit (valid & tag match):
    - upd_taken=1: counter saturating +1, target <= upd_target.
    - upd_taken=0: counter saturating -1, target unchanged.
    - upd_hit_count +1.
  - Upd-miss with upd_taken=1:
    - Allocate: valid=1, tag, target = upd_target, counter = 2**(CNT_W-1) (weakly taken).
    - Overwrites any aliasing entry.
    - alloc_count +1.
  - Upd-miss with upd_taken=0: no state change, no stat change.
- Counter saturation bounds: never exceeds 2**CNT_W-1 and never drops below 0.
- Statistics counters saturate at all-ones; they do not wrap. They are cleared only by rst_n, not by flush.
- Flush:
  - Clears every valid bit at the next edge; counters, tags and targets are retained.
  - Flush has priority: an update in the same cycle is dropped entirely, including stats.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new state is visible from the next cycle; no bypass.
- Reset asserted mid-update: the update is lost and reset values hold until rst_n rises. The first update is accepted on the first rising edge after deassertion.
- No other state machine: the block is arrays plus counters. All storage is written only at posedge clk or by async reset.

Test Plan (IDX_W=4, CNT_W=2):
1. Reset, then pc4_f=0x44 (idx 1, tag 1) -> hit_f=0, taken_f=0, target_f=0, both stats=0.
2. Update pc4 0x44 taken, target 0x100. Next cycle pc4_f=0x44 -> hit_f=1, taken_f=1, target_f=0x100, alloc_count=1.
3. Three not-taken updates to 0x44 -> counter 2→1→0→0; taken_f=0 after the first, hit_f stays 1, upd_hit_count=3. Two taken updates -> counter 2, taken_f=1.
4. Update pc4 0x84 (idx 1, tag 2) taken, target 0x200 -> lookup 0x44 gives hit_f=0; lookup 0x84 gives hit_f=1, target_f=0x200; alloc_count increments.
5. flush=1 with upd_valid=1 in the same cycle -> next cycle every lookup gives hit_f=0 and stats are unchanged. A subsequent taken update to 0x44 reallocates it with counter 2.
6. Lookup 0x44 in the same cycle as an allocating update to 0x44 -> hit_f=0 that cycle, 1 the next. Drop rst_n mid-run without a clock -> hit_f falls to 0 immediately.
